lcm_from_gcd: RTL and testbench

//   Downstream stage of the gcd unit: takes an operand pair (a, b) and the settled gcd value g.

---
 rtl/lcm_from_gcd_pkg.sv | 12 +
 rtl/lcm_div_step.sv | 30 +++
 rtl/lcm_from_gcd.sv | 180 ++++++++++++++++++
 tb/tb_lcm_from_gcd.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/lcm_from_gcd_pkg.sv
// Shared definitions for the gcd/lcm datapath: FSM state encoding and default width.
// The encoding is fixed because the gcd unit and the sequencer decode the same values.
package lcm_from_gcd_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

endpackage

// File: rtl/lcm_div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder and
// subtract the divisor when it fits.
module lcm_div_step
  import lcm_from_gcd_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] rem_shift;
  logic [WIDTH+1:0] g_ext;

  always_comb begin
    rem_shift = {rem, a_bit};
    g_ext     = {2'b00, g};
    q_bit     = (rem_shift >= g_ext);
    // The remainder stays below g, so the difference always fits in WIDTH+1 bits.
    if (q_bit) begin
      rem_next = (WIDTH+1)'(rem_shift - g_ext);
    end else begin
      rem_next = (WIDTH+1)'(rem_shift);
    end
  end

endmodule

// File: rtl/lcm_from_gcd.sv
// lcm(a,b) = (a/g)*b from a settled gcd: restoring divider then shift-add multiplier,
// with valid/ready handshakes on both sides and one operation in flight.
module lcm_from_gcd
  import lcm_from_gcd_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   g,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] lcm,
  output logic               err
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   g_q, g_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] lcm_q, lcm_d;
  logic               err_q, err_d;

  logic [WIDTH:0]     step_rem_in;
  logic               step_a_bit;
  logic [WIDTH-1:0]   step_g;
  logic [WIDTH:0]     step_rem_next;
  logic               step_q_bit;
  logic [2*WIDTH-1:0] acc_next;

  lcm_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (step_rem_in),
    .a_bit    (step_a_bit),
    .g        (step_g),
    .rem_next (step_rem_next),
    .q_bit    (step_q_bit)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign lcm       = lcm_q;
  assign err       = err_q;

  // In IDLE the divider sees the incoming operands, so the accept edge already
  // performs the first division step; DIV then needs only WIDTH-1 more edges.
  always_comb begin
    if (state_q == IDLE) begin
      step_rem_in = '0;
      step_a_bit  = a[WIDTH-1];
      step_g      = g;
    end else begin
      step_rem_in = rem_q;
      step_a_bit  = a_sh_q[WIDTH-1];
      step_g      = g_q;
    end
  end

  always_comb begin
    acc_next = {acc_q[2*WIDTH-2:0], 1'b0};
    if (quo_q[WIDTH-1]) begin
      acc_next = acc_next + {{WIDTH{1'b0}}, b_q};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_d     = b_q;
    g_d     = g_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    acc_d   = acc_q;
    lcm_d   = lcm_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d = {a[WIDTH-2:0], 1'b0};
          b_d    = b;
          g_d    = g;
          if ((a == '0) || (b == '0)) begin
            state_d = DONE;
            lcm_d   = '0;
            err_d   = 1'b0;
          end else if (g == '0) begin
            state_d = DONE;
            lcm_d   = '0;
            err_d   = 1'b1;
          end else begin
            state_d = DIV;
            cnt_d   = CNT_W'(WIDTH);
            rem_d   = step_rem_next;
            quo_d   = {{(WIDTH-1){1'b0}}, step_q_bit};
            acc_d   = '0;
          end
        end
      end

      DIV: begin
        rem_d  = step_rem_next;
        quo_d  = {quo_q[WIDTH-2:0], step_q_bit};
        a_sh_d = {a_sh_q[WIDTH-2:0], 1'b0};
        if (cnt_q == CNT_W'(2)) begin
          if (step_rem_next != '0) begin
            state_d = DONE;
            lcm_d   = '0;
            err_d   = 1'b1;
          end else begin
            state_d = MUL;
            cnt_d   = CNT_W'(WIDTH);
            acc_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      MUL: begin
        acc_d = acc_next;
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          lcm_d   = acc_next;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_q     <= '0;
      g_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      acc_q   <= '0;
      lcm_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_q     <= b_d;
      g_q     <= g_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      acc_q   <= acc_d;
      lcm_q   <= lcm_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lcm_from_gcd.sv
// Directed and randomized bench for lcm_from_gcd against an arithmetic reference model.
module tb_lcm_from_gcd;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a, b, g;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] lcm;
  logic           err;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  lcm_from_gcd #(.WIDTH(W)) dut (
    .clock     (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .g         (g),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lcm       (lcm),
    .err       (err)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gcd_ref(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Result and edge count (accept edge counted as 1) from the arithmetic definition.
  task automatic model(input int ta, input int tb_, input int tg,
                       output int exp_lcm, output int exp_err, output int exp_lat);
    if (ta == 0 || tb_ == 0) begin
      exp_lcm = 0; exp_err = 0; exp_lat = 1;
    end else if (tg == 0) begin
      exp_lcm = 0; exp_err = 1; exp_lat = 1;
    end else if (ta % tg != 0) begin
      exp_lcm = 0; exp_err = 1; exp_lat = W;
    end else begin
      exp_lcm = (ta / tg) * tb_; exp_err = 0; exp_lat = 2 * W;
    end
  endtask

  // Entered and left at a negedge with the DUT idle (unless out_ready is low).
  task automatic do_op(input int ta, input int tb_, input int tg, input string tag);
    int n, el, ee, lat;
    model(ta, tb_, tg, el, ee, lat);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    a = W'(ta); b = W'(tb_); g = W'(tg); in_valid = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " lcm"}, 32'(lcm), 32'(el));
    check({tag, " err"}, 32'(err), 32'(ee));
    if (out_ready) begin
      @(negedge clk);
      check({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    int ra, rb, rg, sel, seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; g = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset lcm", 32'(lcm), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);

    do_op(10, 5, 5, "t1");
    do_op(255, 254, 1, "t2a");
    do_op(119, 49, 7, "t2b");
    do_op(0, 7, 7, "t3a");
    do_op(0, 0, 0, "t3b");
    do_op(12, 18, 5, "t4a");
    do_op(3, 4, 0, "t4b");

    // Backpressure: result held, extra in_valid pulses ignored.
    out_ready = 1'b0;
    do_op(17, 14, 1, "bp");
    repeat (5) begin
      a = 8'd5; b = 8'd5; g = 8'd5; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp hold out_valid", 32'(out_valid), 32'd1);
      check("bp hold in_ready", 32'(in_ready), 32'd0);
      check("bp hold lcm", 32'(lcm), 32'd238);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    check("bp kept lcm", 32'(lcm), 32'd238);
    check("bp kept err", 32'(err), 32'd0);
    do_op(9, 6, 3, "b2b");

    // Reset during the 4th DIV cycle drops the operation.
    a = 8'd255; b = 8'd254; g = 8'd1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst mid in_ready", 32'(in_ready), 32'd1);
    check("rst mid out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    check("rst no spurious result", 32'(seen), 32'd0);
    do_op(119, 49, 7, "after rst");

    for (int i = 0; i < 25; i++) begin
      ra  = int'($urandom_range(0, 255));
      rb  = int'($urandom_range(0, 255));
      sel = int'($urandom_range(0, 5));
      if (sel == 0) rg = int'($urandom_range(0, 255));
      else if (sel == 1) begin ra = 0; rg = rb; end
      else if (ra == 0 && rb == 0) rg = 0;
      else rg = gcd_ref(ra, rb);
      do_op(ra, rb, rg, $sformatf("rnd%0d a=%0d b=%0d g=%0d", i, ra, rb, rg));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
